// File: rtl/scc_pkg.sv
// Shared definitions for the SCC slave interface.
//   scc_state_e : frame decoder states
//   SCC_ADDR_W  : register address width carried by a frame
//   SCC_DATA_W  : register data width carried by a frame
//   SCC_CNT_W   : width of the bit counter used while shifting
package scc_pkg;

  localparam int SCC_ADDR_W = 12;
  localparam int SCC_DATA_W = 32;
  localparam int SCC_CNT_W  = 6;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA_IN,
    WAIT_LOAD,
    ACCESS,
    DATA_OUT
  } scc_state_e;

endpackage

// File: rtl/scc_sync.sv
// Synchroniser bank for the asynchronous SCC pins plus CFGCLK edge pulses.
// Every pin goes through the same number of flops, so the serial data,
// load and direction bits stay aligned with the synchronised clock.
//   clk, reset          : system clock, synchronous active-high reset
//   cfgclk .. cfgdatain : raw asynchronous SCC inputs
//   nrst_sync, load_sync, wnr_sync, din_sync : synchronised copies
//   rise, fall          : one-cycle pulses on synchronised CFGCLK edges
module scc_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic cfgclk,
  input  logic ncfgrst,
  input  logic cfgload,
  input  logic cfgwnr,
  input  logic cfgdatain,
  output logic nrst_sync,
  output logic load_sync,
  output logic wnr_sync,
  output logic din_sync,
  output logic rise,
  output logic fall
);

  // Bit order inside each stage: {cfgclk, ncfgrst, cfgload, cfgwnr, cfgdatain}
  logic [4:0] sync_q [SYNC_STAGES];
  logic [4:0] last;
  logic       clk_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      clk_d <= 1'b0;
    end else begin
      sync_q[0] <= {cfgclk, ncfgrst, cfgload, cfgwnr, cfgdatain};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      clk_d <= last[4];
    end
  end

  assign last      = sync_q[SYNC_STAGES-1];
  assign nrst_sync = last[3];
  assign load_sync = last[2];
  assign wnr_sync  = last[1];
  assign din_sync  = last[0];
  assign rise      = last[4] & ~clk_d;
  assign fall      = ~last[4] & clk_d;

endmodule

// File: rtl/scc_slave_if.sv
// SCC serial slave: decodes one frame (12-bit address, optional 32-bit
// write data, LOAD strobe) into a single register write or read, and shifts
// read data back out LSB first.
//   CLK, RESET          : system clock, synchronous active-high reset
//   CFGCLK, nCFGRST, CFGLOAD, CFGWnR, CFGDATAIN : asynchronous SCC inputs
//   CFGDATAOUT          : serial read data, valid while CFGCLK is high
//   REG_ADDR/REG_WDATA  : access address / write data, held during ACCESS
//   REG_WR/REG_RD       : access request
//   REG_RDATA/REG_ACK   : access completion
//   BUSY                : frame in progress (state != IDLE)
//   ERR, ERR_CLR        : sticky protocol/timeout error and its clear
//   dbg_state           : current decoder state
//
// Register port handshake: REG_WR or REG_RD rises together with a stable
// REG_ADDR (and REG_WDATA) and stays high through the cycle in which REG_ACK
// is sampled high; it falls on the following edge. REG_RDATA is taken only
// in that ACK cycle. If no ACK arrives within ACK_TIMEOUT cycles the request
// is withdrawn and any later ACK is ignored.
module scc_slave_if
  import scc_pkg::*;
#(
  parameter int          SYNC_STAGES   = 2,
  parameter int          ACK_TIMEOUT   = 255,
  parameter logic [31:0] TIMEOUT_RDATA = 32'hDEAD_DEAD
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  CFGCLK,
  input  logic                  nCFGRST,
  input  logic                  CFGLOAD,
  input  logic                  CFGWnR,
  input  logic                  CFGDATAIN,
  output logic                  CFGDATAOUT,
  output logic [SCC_ADDR_W-1:0] REG_ADDR,
  output logic [SCC_DATA_W-1:0] REG_WDATA,
  output logic                  REG_WR,
  output logic                  REG_RD,
  input  logic [SCC_DATA_W-1:0] REG_RDATA,
  input  logic                  REG_ACK,
  output logic                  BUSY,
  output logic                  ERR,
  input  logic                  ERR_CLR,
  output scc_state_e            dbg_state
);

  localparam int TIMER_W = $clog2(ACK_TIMEOUT + 1);

  logic nrst_sync, load_sync, wnr_sync, din_sync, rise, fall;

  scc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (CLK),
    .reset     (RESET),
    .cfgclk    (CFGCLK),
    .ncfgrst   (nCFGRST),
    .cfgload   (CFGLOAD),
    .cfgwnr    (CFGWnR),
    .cfgdatain (CFGDATAIN),
    .nrst_sync (nrst_sync),
    .load_sync (load_sync),
    .wnr_sync  (wnr_sync),
    .din_sync  (din_sync),
    .rise      (rise),
    .fall      (fall)
  );

  scc_state_e            state_q, state_d;
  logic [SCC_CNT_W-1:0]  cnt_q, cnt_d;
  logic [SCC_ADDR_W-1:0] addr_q, addr_d;
  logic [SCC_DATA_W-1:0] wdata_q, wdata_d;
  logic [SCC_DATA_W-1:0] rdata_q, rdata_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic                  wnr_q, wnr_d;
  logic                  dout_q, dout_d;
  logic                  err_q, err_set;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      timer_q <= '0;
      wnr_q   <= 1'b0;
      dout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      timer_q <= timer_d;
      wnr_q   <= wnr_d;
      dout_q  <= dout_d;
      // A new error wins over a clear arriving in the same cycle.
      if (err_set)      err_q <= 1'b1;
      else if (ERR_CLR) err_q <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wnr_d   = wnr_q;
    dout_d  = dout_q;
    timer_d = '0;
    err_set = 1'b0;

    if (!nrst_sync) begin
      // SCC reset silently abandons the frame, including a pending access.
      state_d = IDLE;
      cnt_d   = '0;
      dout_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            if (load_sync) begin
              err_set = 1'b1;
            end else begin
              addr_d  = {addr_q[SCC_ADDR_W-2:0], din_sync};
              wnr_d   = wnr_sync;
              cnt_d   = SCC_CNT_W'(1);
              state_d = ADDR;
            end
          end
        end

        ADDR: begin
          if (rise) begin
            if (load_sync) begin
              err_set = 1'b1;
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              addr_d = {addr_q[SCC_ADDR_W-2:0], din_sync};
              if (cnt_q == SCC_CNT_W'(SCC_ADDR_W - 1)) begin
                cnt_d   = '0;
                state_d = wnr_q ? DATA_IN : WAIT_LOAD;
              end else begin
                cnt_d = cnt_q + SCC_CNT_W'(1);
              end
            end
          end
        end

        DATA_IN: begin
          if (rise) begin
            if (load_sync) begin
              err_set = 1'b1;
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              wdata_d = {wdata_q[SCC_DATA_W-2:0], din_sync};
              if (cnt_q == SCC_CNT_W'(SCC_DATA_W - 1)) begin
                cnt_d   = '0;
                state_d = WAIT_LOAD;
              end else begin
                cnt_d = cnt_q + SCC_CNT_W'(1);
              end
            end
          end
        end

        WAIT_LOAD: begin
          if (rise) begin
            if (load_sync) begin
              state_d = ACCESS;
            end else begin
              err_set = 1'b1;
              state_d = IDLE;
            end
          end
        end

        ACCESS: begin
          // CFGCLK edges are deliberately ignored here.
          timer_d = timer_q + TIMER_W'(1);
          if (REG_ACK) begin
            if (wnr_q) begin
              state_d = IDLE;
            end else begin
              rdata_d = REG_RDATA;
              dout_d  = REG_RDATA[0];
              cnt_d   = '0;
              state_d = DATA_OUT;
            end
          end else if (timer_q == TIMER_W'(ACK_TIMEOUT - 1)) begin
            err_set = 1'b1;
            if (wnr_q) begin
              state_d = IDLE;
            end else begin
              rdata_d = TIMEOUT_RDATA;
              dout_d  = TIMEOUT_RDATA[0];
              cnt_d   = '0;
              state_d = DATA_OUT;
            end
          end
        end

        DATA_OUT: begin
          if (rise) begin
            if (cnt_q == SCC_CNT_W'(SCC_DATA_W - 1)) begin
              dout_d  = 1'b0;
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q + SCC_CNT_W'(1);
            end
          end else if (fall && cnt_q != '0) begin
            // The fall that closes the LOAD clock can land here before any
            // data rise; shifting only after a rise keeps bit 0 on the pin.
            rdata_d = rdata_q >> 1;
            dout_d  = rdata_q[1];
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  assign REG_WR     = (state_q == ACCESS) &&  wnr_q;
  assign REG_RD     = (state_q == ACCESS) && !wnr_q;
  assign REG_ADDR   = addr_q;
  assign REG_WDATA  = wdata_q;
  assign CFGDATAOUT = dout_q;
  assign BUSY       = (state_q != IDLE);
  assign ERR        = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_scc_slave_if.sv
// Directed-plus-random bench for scc_slave_if. A bench-side SCC master
// shifts frames in, a register-bank responder answers REG_WR/REG_RD, and a
// frame-level model predicts which accesses occur and what read data the
// master reassembles.
module tb_scc_slave_if;
  import scc_pkg::*;

  localparam int H         = 6;    // CFGCLK half period in CLK cycles
  localparam int ACC_W     = 45;   // {is_write, addr, wdata}
  localparam int T_OUT     = 255;
  localparam logic [31:0] T_DATA = 32'hDEAD_DEAD;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        cfgclk = 1'b0, ncfgrst = 1'b1, cfgload = 1'b0;
  logic        cfgwnr = 1'b0, cfgdatain = 1'b0, cfgdataout;
  logic [11:0] reg_addr;
  logic [31:0] reg_wdata, reg_rdata;
  logic        reg_wr, reg_rd, reg_ack, busy, err, err_clr = 1'b0;
  scc_state_e  dbg_state;

  scc_slave_if dut (
    .CLK(clk), .RESET(reset), .CFGCLK(cfgclk), .nCFGRST(ncfgrst),
    .CFGLOAD(cfgload), .CFGWnR(cfgwnr), .CFGDATAIN(cfgdatain),
    .CFGDATAOUT(cfgdataout), .REG_ADDR(reg_addr), .REG_WDATA(reg_wdata),
    .REG_WR(reg_wr), .REG_RD(reg_rd), .REG_RDATA(reg_rdata), .REG_ACK(reg_ack),
    .BUSY(busy), .ERR(err), .ERR_CLR(err_clr), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [ACC_W-1:0] exp_q[$];
  logic [ACC_W-1:0] obs_q[$];
  logic [31:0] bank      [logic [11:0]];  // responder's register bank
  logic [31:0] model_mem [logic [11:0]];  // model's view of the bank

  int   ack_delay  = 0;
  bit   ack_en     = 1'b1;
  bit   inject_ack = 1'b0;
  int   both_hi    = 0;
  int   rd_len     = 0;

  // register-bank responder
  initial begin
    int ack_wait;
    ack_wait  = 0;
    reg_ack   = 1'b0;
    reg_rdata = '0;
    forever begin
      @(posedge clk); #1;
      reg_ack = 1'b0;
      if (inject_ack) begin
        reg_ack   = 1'b1;
        reg_rdata = $urandom;
      end else if ((reg_wr || reg_rd) && ack_en) begin
        if (ack_wait == 0) begin
          reg_ack = 1'b1;
          if (reg_wr) bank[reg_addr] = reg_wdata;
          else reg_rdata = bank.exists(reg_addr) ? bank[reg_addr] : 32'h0;
          ack_wait = ack_delay;
        end else begin
          ack_wait--;
        end
      end else begin
        ack_wait = ack_delay;
      end
    end
  end

  // access monitor
  initial begin
    logic wr_prev, rd_prev;
    wr_prev = 1'b0;
    rd_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reg_wr && reg_rd) both_hi++;
      if (reg_wr && !wr_prev) obs_q.push_back({1'b1, reg_addr, reg_wdata});
      if (reg_rd && !rd_prev) begin
        obs_q.push_back({1'b0, reg_addr, 32'h0});
        rd_len = 1;
      end else if (reg_rd) begin
        rd_len++;
      end
      wr_prev = reg_wr;
      rd_prev = reg_rd;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_sb(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check(tag, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a);
    return model_mem.exists(a) ? model_mem[a] : 32'h0;
  endfunction

  // driver tasks (SCC master)
  task automatic rise_bit(input logic load, input logic din);
    @(negedge clk);
    cfgload   = load;
    cfgdatain = din;
    repeat (H) @(negedge clk);
    cfgclk = 1'b1;
    repeat (H) @(negedge clk);
    cfgclk = 1'b0;
  endtask

  task automatic send_hdr(input logic wr, input logic [11:0] a);
    cfgwnr = wr;
    for (int i = 11; i >= 0; i--) begin
      rise_bit(1'b0, a[i]);
      cfgwnr = 1'($urandom_range(0, 1));  // must be ignored once latched
    end
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin @(negedge clk); n++; end
  endtask

  task automatic wait_rd_done();
    int n;
    n = 0;
    while (!reg_rd && n < 50) begin @(negedge clk); n++; end
    while (reg_rd && n < 400) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
  endtask

  task automatic read_word(output logic [31:0] v);
    v = '0;
    for (int i = 0; i < 32; i++) begin
      repeat (H) @(negedge clk);
      cfgclk = 1'b1;
      @(negedge clk);
      v[i] = cfgdataout;
      repeat (H - 1) @(negedge clk);
      cfgclk = 1'b0;
    end
  endtask

  task automatic write_frame(input logic [11:0] a, input logic [31:0] d);
    send_hdr(1'b1, a);
    for (int i = 31; i >= 0; i--) rise_bit(1'b0, d[i]);
    rise_bit(1'b1, 1'b0);
    cfgload = 1'b0;
    model_mem[a] = d;
    exp_q.push_back({1'b1, a, d});
    wait_idle(400);
  endtask

  task automatic read_frame(input logic [11:0] a, output logic [31:0] v);
    send_hdr(1'b0, a);
    rise_bit(1'b1, 1'b0);
    cfgload = 1'b0;
    exp_q.push_back({1'b0, a, 32'h0});
    wait_rd_done();
    read_word(v);
    wait_idle(50);
  endtask

  task automatic clear_err();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    @(negedge clk);
  endtask

  logic [11:0] addr_pool [4] = '{12'h010, 12'h2A7, 12'h7FF, 12'hFFF};

  initial begin
    logic [31:0] v, d, e;
    logic [11:0] a;
    int n;

    // reset state
    repeat (5) @(negedge clk);
    check("rst_wr", reg_wr, 0);
    check("rst_rd", reg_rd, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_dout", cfgdataout, 0);
    check("rst_addr", reg_addr, 0);
    check("rst_wdata", reg_wdata, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // write frame
    ack_delay = $urandom_range(0, 5);
    write_frame(12'hCCC, 32'hCCCC_CCCC);
    check_sb("wr_ccc");
    check("wr_ccc_err", err, 0);
    check("wr_ccc_busy", busy, 0);

    // read frame, ACK after 3 cycles
    bank[12'h123] = 32'hA5A5_0F0F;
    model_mem[12'h123] = 32'hA5A5_0F0F;
    ack_delay = 3;
    read_frame(12'h123, v);
    check("rd_123_data", v, 32'hA5A5_0F0F);
    check("rd_123_busy", busy, 0);
    check("rd_123_dout", cfgdataout, 0);
    check("rd_123_err", err, 0);
    check_sb("rd_123");

    // LOAD after 5 address bits
    cfgwnr = 1'b1;
    for (int i = 0; i < 5; i++) rise_bit(1'b0, 1'($urandom_range(0, 1)));
    rise_bit(1'b1, 1'b0);
    cfgload = 1'b0;
    repeat (4) @(negedge clk);
    check("ld_early_err", err, 1);
    check("ld_early_busy", busy, 0);
    check_sb("ld_early");
    clear_err();
    check("ld_early_clr", err, 0);
    a = addr_pool[$urandom_range(0, 3)];
    d = $urandom;
    write_frame(a, d);
    check_sb("after_clr_wr");
    check("after_clr_err", err, 0);

    // LOAD on the first rise of a frame
    rise_bit(1'b1, 1'b0);
    cfgload = 1'b0;
    repeat (4) @(negedge clk);
    check("ld_idle_err", err, 1);
    check("ld_idle_busy", busy, 0);
    clear_err();

    // missing LOAD after a read header
    send_hdr(1'b0, 12'h5A5);
    rise_bit(1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("no_ld_err", err, 1);
    check("no_ld_busy", busy, 0);
    check_sb("no_ld");
    clear_err();

    // read with no ACK: timeout
    ack_en = 1'b0;
    read_frame(12'h3A5, v);
    check("to_rd_len", rd_len, T_OUT);
    check("to_err", err, 1);
    check("to_data", v, T_DATA);
    check("to_busy", busy, 0);
    check_sb("to");
    ack_en = 1'b1;
    clear_err();

    // nCFGRST in the middle of write data
    send_hdr(1'b1, 12'h0F0);
    for (int i = 0; i < 10; i++) rise_bit(1'b0, 1'($urandom_range(0, 1)));
    @(negedge clk); ncfgrst = 1'b0;
    repeat (6) @(negedge clk);
    check("nrst_busy", busy, 0);
    ncfgrst = 1'b1;
    repeat (4) @(negedge clk);
    check("nrst_err", err, 0);
    check_sb("nrst_abort");
    a = addr_pool[$urandom_range(0, 3)];
    d = $urandom;
    ack_delay = $urandom_range(0, 4);
    write_frame(a, d);
    read_frame(a, v);
    check("nrst_next_rd", v, d);
    check_sb("nrst_next");

    // RESET while a read is waiting for ACK
    ack_delay = 40;
    send_hdr(1'b0, 12'h456);
    rise_bit(1'b1, 1'b0);
    cfgload = 1'b0;
    exp_q.push_back({1'b0, 12'h456, 32'h0});
    n = 0;
    while (!reg_rd && n < 50) begin @(negedge clk); n++; end
    check("rst_acc_rd_seen", reg_rd, 1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_acc_rd", reg_rd, 0);
    check("rst_acc_busy", busy, 0);
    check("rst_acc_addr", reg_addr, 0);
    check("rst_acc_dout", cfgdataout, 0);
    reset = 1'b0;
    inject_ack = 1'b1;
    @(negedge clk);
    inject_ack = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_ack_busy", busy, 0);
    check("rst_ack_err", err, 0);
    check_sb("rst_acc");

    // randomized frames
    for (int k = 0; k < 8; k++) begin
      a = addr_pool[$urandom_range(0, 3)];
      ack_delay = $urandom_range(0, 6);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        write_frame(a, d);
      end else begin
        e = model_read(a);
        read_frame(a, v);
        check("rand_rd_data", v, e);
      end
      check_sb("rand");
      check("rand_err", err, 0);
      check("rand_busy", busy, 0);
    end

    check("wr_rd_overlap", both_hi, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
